// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and forward-select encoding.
// Types only, no logic, so no latency.
// No flow control lives here.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        S_INIT,
        S_RUN,
        S_FLUSH
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EXE = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_e;

endpackage

// File: rtl/fwd_select.sv
// One ID operand: compares against EXE/MEM/WB destinations and picks the youngest forward source.
// Purely combinational, zero latency.
// No flow control; load_hit tells the parent that a stall is needed.
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              read_en,
    input  logic [REG_AW-1:0] addr,
    input  logic              exe_reg_write,
    input  logic              exe_load,
    input  logic [REG_AW-1:0] exe_write_addr,
    input  logic              mem_reg_write,
    input  logic              mem_load,
    input  logic [REG_AW-1:0] mem_write_addr,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_addr,
    output fwd_sel_e          sel,
    output logic              load_hit
);

    logic exe_hit;
    logic mem_hit;
    logic wb_hit;

    assign exe_hit = read_en && exe_reg_write && (addr == exe_write_addr);
    assign mem_hit = read_en && mem_reg_write && (addr == mem_write_addr);
    assign wb_hit  = read_en && wb_reg_write  && (addr == wb_write_addr);

    // A load result is not ready in EXE/MEM; the stall covers it, so the select is a don't-care there.
    always_comb begin
        sel = FWD_RF;
        if (exe_hit) begin
            sel = exe_load ? FWD_RF : FWD_EXE;
        end else if (mem_hit) begin
            sel = mem_load ? FWD_RF : FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    assign load_hit = (exe_hit && exe_load) || (mem_hit && mem_load);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencer: RAW forwarding, load-use stall, branch flush, warm-up hold, perf counters.
// Control outputs are combinational from state and stage info; counters update one cycle later.
// Stalls PC and IF/ID on load-use; flush overrides stall so a taken branch always redirects fetch.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int INIT_CYCLES  = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_reg1_read,
    input  logic [REG_AW-1:0] id_reg1_addr,
    input  logic              id_reg2_read,
    input  logic [REG_AW-1:0] id_reg2_addr,
    input  logic              id_sw_read,
    input  logic [REG_AW-1:0] id_sw_addr,
    input  logic              exe_reg_write,
    input  logic              exe_DM_read,
    input  logic [REG_AW-1:0] exe_write_addr,
    input  logic              mem_reg_write,
    input  logic              mem_DM_read,
    input  logic [REG_AW-1:0] mem_write_addr,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_write_addr,
    input  logic              branch_true,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idexe_flush,
    output logic [1:0]        fwd_reg1_sel,
    output logic [1:0]        fwd_reg2_sel,
    output logic [1:0]        fwd_sw_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int IN_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    ctrl_state_e     state, state_nxt;
    logic [IN_W-1:0] init_cnt, init_cnt_nxt;
    logic [FL_W-1:0] flush_left, flush_left_nxt;
    fwd_sel_e        sel_reg1, sel_reg2, sel_sw;
    logic            hit_reg1, hit_reg2, hit_sw;
    logic            load_use;
    logic            stall_inc;
    logic            flush_inc;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_reg1 (
        .read_en(id_reg1_read), .addr(id_reg1_addr),
        .exe_reg_write(exe_reg_write), .exe_load(exe_DM_read), .exe_write_addr(exe_write_addr),
        .mem_reg_write(mem_reg_write), .mem_load(mem_DM_read), .mem_write_addr(mem_write_addr),
        .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
        .sel(sel_reg1), .load_hit(hit_reg1)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_reg2 (
        .read_en(id_reg2_read), .addr(id_reg2_addr),
        .exe_reg_write(exe_reg_write), .exe_load(exe_DM_read), .exe_write_addr(exe_write_addr),
        .mem_reg_write(mem_reg_write), .mem_load(mem_DM_read), .mem_write_addr(mem_write_addr),
        .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
        .sel(sel_reg2), .load_hit(hit_reg2)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_sw (
        .read_en(id_sw_read), .addr(id_sw_addr),
        .exe_reg_write(exe_reg_write), .exe_load(exe_DM_read), .exe_write_addr(exe_write_addr),
        .mem_reg_write(mem_reg_write), .mem_load(mem_DM_read), .mem_write_addr(mem_write_addr),
        .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
        .sel(sel_sw), .load_hit(hit_sw)
    );

    assign fwd_reg1_sel = sel_reg1;
    assign fwd_reg2_sel = sel_reg2;
    assign fwd_sw_sel   = sel_sw;
    assign load_use     = hit_reg1 || hit_reg2 || hit_sw;

    always_comb begin
        state_nxt      = state;
        init_cnt_nxt   = init_cnt;
        flush_left_nxt = flush_left;
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        idexe_flush    = 1'b0;
        stall_inc      = 1'b0;
        case (state)
            S_INIT: begin
                pc_stall    = 1'b1;
                ifid_flush  = 1'b1;
                idexe_flush = 1'b1;
                if (init_cnt == IN_W'(INIT_CYCLES - 1)) begin
                    state_nxt = S_RUN;
                end else begin
                    init_cnt_nxt = init_cnt + IN_W'(1);
                end
            end
            S_RUN: begin
                // Branch beats load-use: the stalled instruction is on the wrong path anyway.
                if (branch_true) begin
                    ifid_flush  = 1'b1;
                    idexe_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_left_nxt = FL_W'(FLUSH_CYCLES - 1);
                        state_nxt      = S_FLUSH;
                    end
                end else if (load_use) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idexe_flush = 1'b1;
                    stall_inc   = 1'b1;
                end
            end
            S_FLUSH: begin
                ifid_flush  = 1'b1;
                idexe_flush = 1'b1;
                if (branch_true) begin
                    flush_left_nxt = FL_W'(FLUSH_CYCLES - 1);
                end else if (flush_left == FL_W'(1)) begin
                    state_nxt = S_RUN;
                end else begin
                    flush_left_nxt = flush_left - FL_W'(1);
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    assign flush_inc = ifid_flush && (state != S_INIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            flush_left <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            init_cnt   <= init_cnt_nxt;
            flush_left <= flush_left_nxt;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario-driven bench for pipe_hazard_ctrl with a per-cycle expectation queue.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       br;
        logic       r1_rd;
        logic [4:0] r1_a;
        logic       r2_rd;
        logic [4:0] r2_a;
        logic       sw_rd;
        logic [4:0] sw_a;
        logic       exe_w;
        logic       exe_ld;
        logic [4:0] exe_a;
        logic       mem_w;
        logic       mem_ld;
        logic [4:0] mem_a;
        logic       wb_w;
        logic [4:0] wb_a;
    } stim_t;

    typedef struct packed {
        logic [9:0]  ctl;
        logic [9:0]  mask;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    // ctl = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1, fwd_reg2, fwd_sw}
    localparam logic [9:0]  C_0   = 10'b0000_00_00_00;
    localparam logic [9:0]  C_I   = 10'b1011_00_00_00;
    localparam logic [9:0]  C_S   = 10'b1101_00_00_00;
    localparam logic [9:0]  C_F   = 10'b0011_00_00_00;
    localparam logic [9:0]  M_ALL = 10'b1111_11_11_11;
    localparam logic [9:0]  M_N1  = 10'b1111_00_11_11;
    localparam logic [9:0]  M_N2  = 10'b1111_11_00_11;
    localparam logic [9:0]  M_NS  = 10'b1111_11_11_00;
    localparam logic [31:0] SAT   = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        id_reg1_read, id_reg2_read, id_sw_read;
    logic [4:0]  id_reg1_addr, id_reg2_addr, id_sw_addr;
    logic        exe_reg_write, exe_DM_read, mem_reg_write, mem_DM_read, wb_reg_write;
    logic [4:0]  exe_write_addr, mem_write_addr, wb_write_addr;
    logic        branch_true;
    logic        pc_stall, ifid_stall, ifid_flush, idexe_flush;
    logic [1:0]  fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel;
    logic [31:0] stall_cnt, flush_cnt;

    int   n_chk;
    int   n_fail;
    exp_t exp_q[$];
    exp_t got;
    logic [9:0] obs;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
        .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
        .id_sw_read(id_sw_read), .id_sw_addr(id_sw_addr),
        .exe_reg_write(exe_reg_write), .exe_DM_read(exe_DM_read), .exe_write_addr(exe_write_addr),
        .mem_reg_write(mem_reg_write), .mem_DM_read(mem_DM_read), .mem_write_addr(mem_write_addr),
        .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
        .branch_true(branch_true),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idexe_flush(idexe_flush),
        .fwd_reg1_sel(fwd_reg1_sel), .fwd_reg2_sel(fwd_reg2_sel), .fwd_sw_sel(fwd_sw_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t f_idle();
        stim_t s;
        s = '0;
        return s;
    endfunction
    function automatic stim_t f_rst();
        stim_t s;
        s = '0; s.rst = 1'b1;
        return s;
    endfunction
    function automatic stim_t f_br();
        stim_t s;
        s = '0; s.br = 1'b1;
        return s;
    endfunction
    function automatic stim_t f_rd1(input logic [4:0] a);
        stim_t s;
        s = '0; s.r1_rd = 1'b1; s.r1_a = a;
        return s;
    endfunction
    function automatic stim_t f_rd2(input logic [4:0] a);
        stim_t s;
        s = '0; s.r2_rd = 1'b1; s.r2_a = a;
        return s;
    endfunction
    function automatic stim_t f_sw(input logic [4:0] a);
        stim_t s;
        s = '0; s.sw_rd = 1'b1; s.sw_a = a;
        return s;
    endfunction
    function automatic stim_t f_exe(input logic [4:0] a, input logic ld);
        stim_t s;
        s = '0; s.exe_w = 1'b1; s.exe_ld = ld; s.exe_a = a;
        return s;
    endfunction
    function automatic stim_t f_mem(input logic [4:0] a, input logic ld);
        stim_t s;
        s = '0; s.mem_w = 1'b1; s.mem_ld = ld; s.mem_a = a;
        return s;
    endfunction
    function automatic stim_t f_wb(input logic [4:0] a);
        stim_t s;
        s = '0; s.wb_w = 1'b1; s.wb_a = a;
        return s;
    endfunction
    function automatic exp_t ex(input logic [9:0] c, input logic [9:0] m,
                                input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e.ctl = c; e.mask = m; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst            = s.rst;
        branch_true    = s.br;
        id_reg1_read   = s.r1_rd;  id_reg1_addr   = s.r1_a;
        id_reg2_read   = s.r2_rd;  id_reg2_addr   = s.r2_a;
        id_sw_read     = s.sw_rd;  id_sw_addr     = s.sw_a;
        exe_reg_write  = s.exe_w;  exe_DM_read    = s.exe_ld; exe_write_addr = s.exe_a;
        mem_reg_write  = s.mem_w;  mem_DM_read    = s.mem_ld; mem_write_addr = s.mem_a;
        wb_reg_write   = s.wb_w;   wb_write_addr  = s.wb_a;
    endtask

    task automatic test_reset();
        stim_t st [3];
        exp_t  ev [3];
        apply(f_rst());
        st = '{f_idle(), f_idle(), f_idle()};
        ev = '{ex(C_I, M_ALL, 0, 0), ex(C_I, M_ALL, 0, 0), ex(C_0, M_ALL, 0, 0)};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL reset[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL reset[%0d] stall_cnt got %0d want %0d", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL reset[%0d] flush_cnt got %0d want %0d", i, flush_cnt, got.fc); end
        end
    endtask

    task automatic test_forward();
        stim_t st [8];
        exp_t  ev [8];
        st = '{f_rd1(5'd3) | f_exe(5'd3, 1'b0),
               f_rd1(5'd3) | f_exe(5'd3, 1'b0) | f_mem(5'd3, 1'b0),
               f_rd1(5'd3) | f_mem(5'd3, 1'b0),
               f_rd1(5'd3) | f_wb(5'd3),
               f_exe(5'd3, 1'b0) | f_mem(5'd3, 1'b0) | f_wb(5'd3),
               f_rd2(5'd9) | f_wb(5'd9) | f_sw(5'd7) | f_mem(5'd7, 1'b0),
               f_rd2(5'd4) | f_mem(5'd4, 1'b0) | f_wb(5'd4),
               f_rd1(5'd6) | f_rd2(5'd0) | f_exe(5'd2, 1'b0) | f_wb(5'd0)};
        ev = '{ex({4'b0, 2'b01, 4'b0}, M_ALL, 0, 0),
               ex({4'b0, 2'b01, 4'b0}, M_ALL, 0, 0),
               ex({4'b0, 2'b10, 4'b0}, M_ALL, 0, 0),
               ex({4'b0, 2'b11, 4'b0}, M_ALL, 0, 0),
               ex(C_0, M_ALL, 0, 0),
               ex({6'b0, 2'b11, 2'b10}, M_ALL, 0, 0),
               ex({6'b0, 2'b10, 2'b00}, M_ALL, 0, 0),
               ex({6'b0, 2'b11, 2'b00}, M_ALL, 0, 0)};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL forward[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL forward[%0d] stall_cnt got %0d want %0d", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL forward[%0d] flush_cnt got %0d want %0d", i, flush_cnt, got.fc); end
        end
    endtask

    task automatic test_load_use();
        stim_t st [8];
        exp_t  ev [8];
        st = '{f_rd2(5'd5) | f_exe(5'd5, 1'b1),
               f_rd2(5'd5) | f_mem(5'd5, 1'b1),
               f_rd2(5'd5) | f_wb(5'd5),
               f_exe(5'd5, 1'b1),
               f_rd1(5'd8) | f_mem(5'd8, 1'b1),
               f_rd1(5'd8) | f_wb(5'd8),
               f_sw(5'd11) | f_exe(5'd11, 1'b1),
               f_idle()};
        ev = '{ex(C_S, M_N2, 0, 0),
               ex(C_S, M_N2, 1, 0),
               ex({6'b0, 2'b11, 2'b00}, M_ALL, 2, 0),
               ex(C_0, M_ALL, 2, 0),
               ex(C_S, M_N1, 2, 0),
               ex({4'b0, 2'b11, 4'b0}, M_ALL, 3, 0),
               ex(C_S, M_NS, 3, 0),
               ex(C_0, M_ALL, 4, 0)};
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL load_use[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL load_use[%0d] stall_cnt got %0d want %0d", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL load_use[%0d] flush_cnt got %0d want %0d", i, flush_cnt, got.fc); end
        end
    endtask

    task automatic test_branch();
        stim_t st [4];
        exp_t  ev [4];
        st = '{f_br(), f_idle(), f_idle(), f_idle()};
        ev = '{ex(C_F, M_ALL, 4, 0), ex(C_F, M_ALL, 4, 1), ex(C_0, M_ALL, 4, 2), ex(C_0, M_ALL, 4, 2)};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL branch[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL branch[%0d] stall_cnt got %0d want %0d", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL branch[%0d] flush_cnt got %0d want %0d", i, flush_cnt, got.fc); end
        end
    endtask

    task automatic test_branch_load_use();
        stim_t st [4];
        exp_t  ev [4];
        st = '{f_br() | f_rd1(5'd5) | f_exe(5'd5, 1'b1),
               f_rd1(5'd5) | f_mem(5'd5, 1'b1),
               f_idle(), f_idle()};
        ev = '{ex(C_F, M_N1, 4, 2), ex(C_F, M_N1, 4, 3), ex(C_0, M_ALL, 4, 4), ex(C_0, M_ALL, 4, 4)};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL br_load[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL br_load[%0d] stall_cnt got %0d want %0d", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL br_load[%0d] flush_cnt got %0d want %0d", i, flush_cnt, got.fc); end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st [6];
        exp_t  ev [6];
        st = '{f_br(), f_br(), f_idle(), f_idle(), f_rd1(5'd2) | f_exe(5'd2, 1'b1), f_idle()};
        ev = '{ex(C_F, M_ALL, 4, 4), ex(C_F, M_ALL, 4, 5), ex(C_F, M_ALL, 4, 6),
               ex(C_0, M_ALL, 4, 7), ex(C_S, M_N1, 4, 7), ex(C_0, M_ALL, 5, 7)};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL b2b[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL b2b[%0d] stall_cnt got %0d want %0d", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL b2b[%0d] flush_cnt got %0d want %0d", i, flush_cnt, got.fc); end
        end
    endtask

    task automatic test_reset_mid();
        stim_t st [5];
        exp_t  ev [5];
        st = '{f_br(), f_rst(), f_idle(), f_br() | f_rd1(5'd5) | f_exe(5'd5, 1'b1), f_idle()};
        ev = '{ex(C_F, M_ALL, 5, 7), ex(C_F, M_ALL, 5, 8), ex(C_I, M_ALL, 0, 0),
               ex(C_I, M_N1, 0, 0), ex(C_0, M_ALL, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL rst_mid[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL rst_mid[%0d] stall_cnt got %0d want %0d", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL rst_mid[%0d] flush_cnt got %0d want %0d", i, flush_cnt, got.fc); end
        end
    endtask

    task automatic test_saturation();
        stim_t st [4];
        exp_t  ev [4];
        force dut.stall_cnt = SAT;
        force dut.flush_cnt = SAT;
        #1;
        release dut.stall_cnt;
        release dut.flush_cnt;
        st = '{f_br(), f_idle(), f_rd1(5'd5) | f_exe(5'd5, 1'b1), f_idle()};
        ev = '{ex(C_F, M_ALL, SAT, SAT), ex(C_F, M_ALL, SAT, SAT),
               ex(C_S, M_N1, SAT, SAT), ex(C_0, M_ALL, SAT, SAT)};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            apply(st[i]);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            got = exp_q.pop_front();
            obs = {pc_stall, ifid_stall, ifid_flush, idexe_flush, fwd_reg1_sel, fwd_reg2_sel, fwd_sw_sel};
            n_chk++;
            if ((obs & got.mask) !== (got.ctl & got.mask)) begin
                n_fail++; $display("FAIL sat[%0d] ctl got %b want %b", i, obs & got.mask, got.ctl & got.mask);
            end
            n_chk++;
            if (stall_cnt !== got.sc) begin n_fail++; $display("FAIL sat[%0d] stall_cnt got %h want %h", i, stall_cnt, got.sc); end
            n_chk++;
            if (flush_cnt !== got.fc) begin n_fail++; $display("FAIL sat[%0d] flush_cnt got %h want %h", i, flush_cnt, got.fc); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        apply(f_rst());
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_branch_load_use();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
